ai_i2s_tx_serializer: RTL

I2S transmit-side serializer: accepts stereo sample pairs over a valid/ready handshake and drives the serial data line (SD) and word select (WS) in standard Philips I2S format. It is MSB first, with a one-SCK delay between the WS edge and the MSB. It sits between the TX sample source (FIFO/DMA) and the pad logic, and is timed by the same SCK-derived `clk_en` strobe scheme as the receive path. Its serial output is bit-compatible with the RX bit deserializer.

---
 rtl/ai_i2s_pkg.sv | 29 ++
 rtl/ai_i2s_tx_sample_buffer.sv | 39 +++
 rtl/ai_i2s_tx_serializer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ai_i2s_pkg.sv
// Shared types and helpers for the I2S transmit path.
package ai_i2s_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_ARM  = 2'd1,
        TX_RUN  = 2'd2
    } tx_state_t;

    typedef enum logic {
        I2S_LEFT  = 1'b0,
        I2S_RIGHT = 1'b1
    } i2s_slot_t;

    localparam int unsigned I2S_MIN_BITS = 2;

    // Slot length is limited to the container width and to at least two bits.
    function automatic logic [5:0] clamp_bits(input logic [5:0] nb, input int unsigned max_bits);
        logic [5:0] r;
        r = nb;
        if ({26'd0, nb} < I2S_MIN_BITS) begin
            r = 6'(I2S_MIN_BITS);
        end else if ({26'd0, nb} > max_bits) begin
            r = 6'(max_bits);
        end
        return r;
    endfunction

endpackage

// File: rtl/ai_i2s_tx_sample_buffer.sv
// One-entry stereo hold register between the sample source and the serializer.
module ai_i2s_tx_sample_buffer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  accept_en,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_left,
    input  logic [DATA_WIDTH-1:0] push_right,
    input  logic                  pop,
    output logic                  ready,
    output logic                  full,
    output logic [DATA_WIDTH-1:0] left_q,
    output logic [DATA_WIDTH-1:0] right_q
);

    assign ready = accept_en && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
        end else if (flush) begin
            full    <= 1'b0;
            left_q  <= '0;
            right_q <= '0;
        end else if (push_valid && ready) begin
            full    <= 1'b1;
            left_q  <= push_left;
            right_q <= push_right;
        end else if (pop) begin
            full    <= 1'b0;
        end
    end

endmodule

// File: rtl/ai_i2s_tx_serializer.sv
// Philips I2S transmitter: MSB first, data launched one SCK after each WS edge.
//   state   | meaning
//   TX_IDLE | disabled, outputs parked (sd=0, ws=1)
//   TX_ARM  | enabled, waiting for a buffered pair and a clk_en tick
//   TX_RUN  | streaming frames, zeros sent when the buffer is empty
module ai_i2s_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clk_en,
    input  logic [5:0]            num_bits,
    input  logic [DATA_WIDTH-1:0] tx_left,
    input  logic [DATA_WIDTH-1:0] tx_right,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  sd,
    output logic                  ws,
    output logic                  frame_start,
    output logic                  underrun
);
    import ai_i2s_pkg::*;

    tx_state_t             state_q, state_d;
    i2s_slot_t             slot_q;
    logic [5:0]            nb_q, bit_cnt, align_sh;
    logic [DATA_WIDTH-1:0] shift_q, right_q, hold_left, hold_right;
    logic                  hold_full, accept_en, run_tick, last_bit, boundary, pop;

    assign align_sh = 6'(DATA_WIDTH) - nb_q;

    ai_i2s_tx_sample_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (!enable),
        .accept_en  (accept_en),
        .push_valid (tx_valid),
        .push_left  (tx_left),
        .push_right (tx_right),
        .pop        (pop),
        .ready      (tx_ready),
        .full       (hold_full),
        .left_q     (hold_left),
        .right_q    (hold_right)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = TX_IDLE;
        end else begin
            case (state_q)
                TX_IDLE: state_d = TX_ARM;
                TX_ARM:  if (clk_en && hold_full) state_d = TX_RUN;
                TX_RUN:  state_d = TX_RUN;
                default: state_d = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        accept_en = enable && (state_q != TX_IDLE);
        last_bit  = (bit_cnt == nb_q - 6'd1);
        run_tick  = enable && clk_en && (state_q == TX_RUN);
        boundary  = enable && clk_en &&
                    (((state_q == TX_ARM) && hold_full) ||
                     ((state_q == TX_RUN) && (slot_q == I2S_RIGHT) && last_bit));
        pop       = boundary && hold_full;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nb_q        <= '0;
            bit_cnt     <= '0;
            slot_q      <= I2S_LEFT;
            shift_q     <= '0;
            right_q     <= '0;
            sd          <= 1'b0;
            ws          <= 1'b1;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else if (!enable) begin
            nb_q        <= '0;
            bit_cnt     <= '0;
            slot_q      <= I2S_LEFT;
            shift_q     <= '0;
            right_q     <= '0;
            sd          <= 1'b0;
            ws          <= 1'b1;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= boundary && hold_full;
            underrun    <= boundary && !hold_full;
            if (state_q == TX_IDLE) begin
                nb_q <= clamp_bits(num_bits, DATA_WIDTH);
            end
            if (run_tick) begin
                sd <= shift_q[DATA_WIDTH-1];
            end
            // Left-align the active word so the MSB always leaves from the top bit.
            if (boundary) begin
                ws      <= 1'b0;
                slot_q  <= I2S_LEFT;
                bit_cnt <= '0;
                shift_q <= hold_full ? (hold_left << align_sh) : '0;
                right_q <= hold_full ? (hold_right << align_sh) : '0;
            end else if (run_tick) begin
                if (last_bit) begin
                    ws      <= ~ws;
                    slot_q  <= I2S_RIGHT;
                    bit_cnt <= '0;
                    shift_q <= right_q;
                end else begin
                    shift_q <= shift_q << 1;
                    bit_cnt <= bit_cnt + 6'd1;
                end
            end
        end
    end

endmodule
